// File: rtl/tlb_responder_if.sv
// CP0 request/response and translation signals of the joint TLB.
interface tlb_responder_if;
  // CP0 request side
  logic [1:0]  MMU_Func_I;
  logic        CP0_RdReq_I;
  logic        CP0_WrReq_I;
  logic [2:0]  MMU_Index_I;
  logic [31:0] EntryHi_I;
  logic [31:0] PageMask_I;
  logic [31:0] EntryLo0_I;
  logic [31:0] EntryLo1_I;
  logic [7:0]  ASID_I;
  // CP0 response side
  logic        MMU_AckP_O;
  logic        MMU_AckR_O;
  logic        MMU_Matched_O;
  logic [2:0]  MMU_Index_O;
  logic [31:0] MMU_EntryHi_O;
  logic [31:0] MMU_PageMask_O;
  logic [31:0] MMU_EntryLo0_O;
  logic [31:0] MMU_EntryLo1_O;
  logic        Busy_O;
  // translation path
  logic        Trans_Req_I;
  logic [31:0] Trans_VAddr_I;
  logic [31:0] Trans_PAddr_O;
  logic        Trans_Miss_O;
  logic        MMU_Req_O;
  logic [31:0] MMU_BadVAddr_O;

  modport master (
    output MMU_Func_I, CP0_RdReq_I, CP0_WrReq_I, MMU_Index_I, EntryHi_I,
           PageMask_I, EntryLo0_I, EntryLo1_I, ASID_I, Trans_Req_I, Trans_VAddr_I,
    input  MMU_AckP_O, MMU_AckR_O, MMU_Matched_O, MMU_Index_O, MMU_EntryHi_O,
           MMU_PageMask_O, MMU_EntryLo0_O, MMU_EntryLo1_O, Busy_O,
           Trans_PAddr_O, Trans_Miss_O, MMU_Req_O, MMU_BadVAddr_O
  );

  modport slave (
    input  MMU_Func_I, CP0_RdReq_I, CP0_WrReq_I, MMU_Index_I, EntryHi_I,
           PageMask_I, EntryLo0_I, EntryLo1_I, ASID_I, Trans_Req_I, Trans_VAddr_I,
    output MMU_AckP_O, MMU_AckR_O, MMU_Matched_O, MMU_Index_O, MMU_EntryHi_O,
           MMU_PageMask_O, MMU_EntryLo0_O, MMU_EntryLo1_O, Busy_O,
           Trans_PAddr_O, Trans_Miss_O, MMU_Req_O, MMU_BadVAddr_O
  );
endinterface

// File: rtl/tlb_responder.sv
// 8-entry joint TLB: CP0 TLBR/TLBW/TLBP service plus parallel address translation.
module tlb_responder #(
  parameter int unsigned ENTRIES = 8
) (
  input logic            Clk,
  input logic            Reset_N,
  tlb_responder_if.slave bus
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned VPN_W  = 19;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned PFN_W  = 20;
  localparam logic [1:0] FUNC_TLBR = 2'b01;
  localparam logic [1:0] FUNC_TLBW = 2'b10;
  localparam logic [1:0] FUNC_TLBP = 2'b11;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef struct packed {
    logic [VPN_W-1:0]  vpn2;
    logic [7:0]        asid;
    logic [MASK_W-1:0] mask;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

  tlb_entry_t entries_q [ENTRIES];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             matched_q, matched_d;
  logic             busy_q, busy_d;
  logic             ack_p_q, ack_p_d;
  logic             req_prev_q;
  logic             ack_r_q;
  logic [31:0]      rd_hi_q, rd_pm_q, rd_lo0_q, rd_lo1_q;
  logic             fault_q;
  logic [31:0]      bad_vaddr_q;

  logic             req_edge_c, accept_c;
  logic             write_fire_c, read_fire_c, probe_start_c, probe_hit_c;
  tlb_entry_t       new_entry_c, rd_entry_c;
  logic             t_hit_c, t_odd_c, t_v_c, t_miss_c;
  tlb_entry_t       t_sel_c;
  logic [PFN_W-1:0] t_pfn_c, t_pmask_c;
  logic [31:0]      t_paddr_c;
  logic             unused_bits_c;

  // VPN2 compare under the page mask, qualified by global bit or ASID
  function automatic logic entry_match(input tlb_entry_t e, input logic [VPN_W-1:0] vpn2,
                                       input logic [7:0] asid);
    logic [VPN_W-1:0] care;
    care = ~{3'b000, e.mask};
    return (((e.vpn2 ^ vpn2) & care) == '0) && (e.g || (e.asid == asid));
  endfunction

  // Request decode: one acceptance per rising edge of the combined strobe, IDLE only
  assign req_edge_c    = (bus.CP0_RdReq_I | bus.CP0_WrReq_I) & ~req_prev_q;
  assign accept_c      = (state_q == S_IDLE) & req_edge_c;
  assign write_fire_c  = accept_c & bus.CP0_WrReq_I & (bus.MMU_Func_I == FUNC_TLBW);
  assign read_fire_c   = accept_c & bus.CP0_RdReq_I & (bus.MMU_Func_I == FUNC_TLBR);
  assign probe_start_c = accept_c & bus.CP0_RdReq_I & (bus.MMU_Func_I == FUNC_TLBP);
  assign probe_hit_c   = entry_match(entries_q[ptr_q], bus.EntryHi_I[31:13], bus.EntryHi_I[7:0]);

  // Pack CP0 registers into the stored entry; G is the AND of both EntryLo G bits
  always_comb begin
    new_entry_c      = '0;
    new_entry_c.vpn2 = bus.EntryHi_I[31:13];
    new_entry_c.asid = bus.EntryHi_I[7:0];
    new_entry_c.mask = bus.PageMask_I[28:13];
    new_entry_c.g    = bus.EntryLo0_I[0] & bus.EntryLo1_I[0];
    new_entry_c.pfn0 = bus.EntryLo0_I[25:6];
    new_entry_c.d0   = bus.EntryLo0_I[2];
    new_entry_c.v0   = bus.EntryLo0_I[1];
    new_entry_c.pfn1 = bus.EntryLo1_I[25:6];
    new_entry_c.d1   = bus.EntryLo1_I[2];
    new_entry_c.v1   = bus.EntryLo1_I[1];
  end

  assign rd_entry_c = entries_q[bus.MMU_Index_I];

  // Entry storage, written by TLBW
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int i = 0; i < int'(ENTRIES); i++) entries_q[i] <= '0;
    end else if (write_fire_c) begin
      entries_q[bus.MMU_Index_I] <= new_entry_c;
    end
  end

  // TLBR read-back registers and single-cycle read ack
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      ack_r_q  <= 1'b0;
      rd_hi_q  <= '0;
      rd_pm_q  <= '0;
      rd_lo0_q <= '0;
      rd_lo1_q <= '0;
    end else begin
      ack_r_q <= read_fire_c;
      if (read_fire_c) begin
        rd_hi_q  <= {rd_entry_c.vpn2, 5'b00000, rd_entry_c.asid};
        rd_pm_q  <= {3'b000, rd_entry_c.mask, 13'd0};
        rd_lo0_q <= {6'd0, rd_entry_c.pfn0, 3'b000, rd_entry_c.d0, rd_entry_c.v0, rd_entry_c.g};
        rd_lo1_q <= {6'd0, rd_entry_c.pfn1, 3'b000, rd_entry_c.d1, rd_entry_c.v1, rd_entry_c.g};
      end
    end
  end

  // Probe FSM state and registered probe outputs
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      index_q    <= '0;
      matched_q  <= 1'b0;
      busy_q     <= 1'b0;
      ack_p_q    <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      index_q    <= index_d;
      matched_q  <= matched_d;
      busy_q     <= busy_d;
      ack_p_q    <= ack_p_d;
      req_prev_q <= bus.CP0_RdReq_I | bus.CP0_WrReq_I;
    end
  end

  // Probe FSM next state: scan one entry per cycle, lowest hit wins
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    index_d   = index_q;
    matched_d = matched_q;
    busy_d    = 1'b0;
    ack_p_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (probe_start_c) begin
          state_d = S_PROBE;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_PROBE: begin
        if (probe_hit_c) begin
          state_d   = S_DONE;
          matched_d = 1'b1;
          index_d   = ptr_q;
        end else if (ptr_q == LAST_IDX) begin
          state_d   = S_DONE;
          matched_d = 1'b0;
          index_d   = '0;
        end else begin
          ptr_d  = ptr_q + IDX_W'(1);
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ack_p_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Parallel lookup: scanning downward leaves the lowest matching index selected
  always_comb begin
    t_hit_c = 1'b0;
    t_sel_c = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (entry_match(entries_q[i], bus.Trans_VAddr_I[31:13], bus.ASID_I)) begin
        t_hit_c = 1'b1;
        t_sel_c = entries_q[i];
      end
    end
  end

  // Physical address formation; kseg0/kseg1 bypass the TLB
  always_comb begin
    t_odd_c   = t_sel_c.mask[2] ? bus.Trans_VAddr_I[16] :
                t_sel_c.mask[0] ? bus.Trans_VAddr_I[14] : bus.Trans_VAddr_I[12];
    t_pfn_c   = t_odd_c ? t_sel_c.pfn1 : t_sel_c.pfn0;
    t_v_c     = t_odd_c ? t_sel_c.v1 : t_sel_c.v0;
    t_pmask_c = {3'b000, t_sel_c.mask, 1'b0};
    t_paddr_c = '0;
    t_miss_c  = 1'b1;
    if (bus.Trans_VAddr_I[31:30] == 2'b10) begin
      t_paddr_c = {3'b000, bus.Trans_VAddr_I[28:0]};
      t_miss_c  = 1'b0;
    end else if (t_hit_c && t_v_c) begin
      t_paddr_c = {(t_pfn_c & ~t_pmask_c) | (bus.Trans_VAddr_I[31:12] & t_pmask_c),
                   bus.Trans_VAddr_I[11:0]};
      t_miss_c  = 1'b0;
    end
  end

  // Fault report pulse and captured faulting address
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      fault_q     <= 1'b0;
      bad_vaddr_q <= '0;
    end else begin
      fault_q <= bus.Trans_Req_I & t_miss_c;
      if (bus.Trans_Req_I && t_miss_c) bad_vaddr_q <= bus.Trans_VAddr_I;
    end
  end

  // Register fields that the entry format does not keep
  assign unused_bits_c = ^{bus.EntryHi_I[12:8], bus.PageMask_I[31:29], bus.PageMask_I[12:0],
                           bus.EntryLo0_I[31:26], bus.EntryLo0_I[5:3],
                           bus.EntryLo1_I[31:26], bus.EntryLo1_I[5:3]};

  assign bus.MMU_AckP_O     = ack_p_q;
  assign bus.MMU_AckR_O     = ack_r_q;
  assign bus.MMU_Matched_O  = matched_q;
  assign bus.MMU_Index_O    = index_q;
  assign bus.MMU_EntryHi_O  = rd_hi_q;
  assign bus.MMU_PageMask_O = rd_pm_q;
  assign bus.MMU_EntryLo0_O = rd_lo0_q;
  assign bus.MMU_EntryLo1_O = rd_lo1_q;
  assign bus.Busy_O         = busy_q;
  assign bus.Trans_PAddr_O  = t_paddr_c;
  assign bus.Trans_Miss_O   = t_miss_c;
  assign bus.MMU_Req_O      = fault_q;
  assign bus.MMU_BadVAddr_O = bad_vaddr_q;

endmodule

// File: tb/tb_tlb_responder.sv
// Scoreboard bench for tlb_responder: CP0 requests, probe latency and translation faults.
module tb_tlb_responder;

  localparam logic [1:0] F_TLBR = 2'b01;
  localparam logic [1:0] F_TLBW = 2'b10;
  localparam logic [1:0] F_TLBP = 2'b11;
  localparam int TMO = 20;

  typedef struct {
    logic       m;
    logic [2:0] idx;
    int         lat;
  } probe_exp_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] pm;
    logic [31:0] lo0;
    logic [31:0] lo1;
  } read_exp_t;

  logic Clk;
  logic Reset_N;
  int   n_cmp;
  int   n_err;

  probe_exp_t  probe_q[$];
  read_exp_t   read_q[$];
  logic [31:0] fault_q[$];

  tlb_responder_if bus ();

  tlb_responder dut (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [31:0] hi, input logic [31:0] pm,
                          input logic [31:0] lo0, input logic [31:0] lo1);
    bus.MMU_Func_I  = F_TLBW;
    bus.MMU_Index_I = idx;
    bus.EntryHi_I   = hi;
    bus.PageMask_I  = pm;
    bus.EntryLo0_I  = lo0;
    bus.EntryLo1_I  = lo1;
    bus.CP0_WrReq_I = 1'b1;
    tick();
    bus.CP0_WrReq_I = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [2:0] idx, input logic [31:0] hi, input logic [31:0] pm,
                         input logic [31:0] lo0, input logic [31:0] lo1, input string name);
    read_exp_t e;
    e.hi = hi; e.pm = pm; e.lo0 = lo0; e.lo1 = lo1;
    read_q.push_back(e);
    bus.MMU_Func_I  = F_TLBR;
    bus.MMU_Index_I = idx;
    bus.CP0_RdReq_I = 1'b1;
    tick();
    bus.CP0_RdReq_I = 1'b0;
    e = read_q.pop_front();
    n_cmp++;
    if (bus.MMU_AckR_O !== 1'b1) begin
      n_err++; $display("FAIL %s ackr: got %b want 1", name, bus.MMU_AckR_O);
    end
    n_cmp++;
    if ({bus.MMU_EntryHi_O, bus.MMU_PageMask_O} !== {e.hi, e.pm}) begin
      n_err++; $display("FAIL %s hi/pm: got %h/%h want %h/%h", name,
                        bus.MMU_EntryHi_O, bus.MMU_PageMask_O, e.hi, e.pm);
    end
    n_cmp++;
    if ({bus.MMU_EntryLo0_O, bus.MMU_EntryLo1_O} !== {e.lo0, e.lo1}) begin
      n_err++; $display("FAIL %s lo0/lo1: got %h/%h want %h/%h", name,
                        bus.MMU_EntryLo0_O, bus.MMU_EntryLo1_O, e.lo0, e.lo1);
    end
    tick();
    n_cmp++;
    if (bus.MMU_AckR_O !== 1'b0) begin
      n_err++; $display("FAIL %s ackr_pulse: got %b want 0", name, bus.MMU_AckR_O);
    end
  endtask

  task automatic do_probe(input logic [31:0] hi, input logic m, input logic [2:0] idx,
                          input int lat, input string name);
    probe_exp_t e;
    int cnt;
    e.m = m; e.idx = idx; e.lat = lat;
    probe_q.push_back(e);
    bus.EntryHi_I   = hi;
    bus.MMU_Func_I  = F_TLBP;
    bus.CP0_RdReq_I = 1'b1;
    tick();
    bus.CP0_RdReq_I = 1'b0;
    cnt = 0;
    while (bus.MMU_AckP_O !== 1'b1 && cnt < TMO) begin
      tick();
      cnt++;
    end
    e = probe_q.pop_front();
    n_cmp++;
    if (cnt >= TMO) begin
      n_err++; $display("FAIL %s ackp_timeout: got none within %0d want %0d", name, TMO, e.lat);
    end else begin
      if (cnt != e.lat) begin
        n_err++; $display("FAIL %s latency: got %0d want %0d", name, cnt, e.lat);
      end
      n_cmp++;
      if ({bus.MMU_Matched_O, bus.MMU_Index_O} !== {e.m, e.idx}) begin
        n_err++; $display("FAIL %s result: got m=%b i=%0d want m=%b i=%0d", name,
                          bus.MMU_Matched_O, bus.MMU_Index_O, e.m, e.idx);
      end
      tick();
      n_cmp++;
      if ({bus.MMU_AckP_O, bus.Busy_O} !== 2'b00) begin
        n_err++; $display("FAIL %s ackp_pulse: got ack=%b busy=%b want 0/0", name,
                          bus.MMU_AckP_O, bus.Busy_O);
      end
    end
  endtask

  task automatic test_reset();
    Reset_N = 1'b1;
    #2;
    Reset_N = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.MMU_AckP_O, bus.MMU_AckR_O, bus.MMU_Matched_O, bus.Busy_O, bus.MMU_Req_O,
         bus.MMU_Index_O} !== 8'd0) begin
      n_err++; $display("FAIL reset_ctrl: got ap=%b ar=%b m=%b b=%b rq=%b i=%0d want all 0",
                        bus.MMU_AckP_O, bus.MMU_AckR_O, bus.MMU_Matched_O, bus.Busy_O,
                        bus.MMU_Req_O, bus.MMU_Index_O);
    end
    n_cmp++;
    if ({bus.MMU_BadVAddr_O, bus.MMU_EntryHi_O, bus.MMU_EntryLo0_O} !== 96'd0) begin
      n_err++; $display("FAIL reset_data: got bv=%h hi=%h lo0=%h want 0", bus.MMU_BadVAddr_O,
                        bus.MMU_EntryHi_O, bus.MMU_EntryLo0_O);
    end
    Reset_N = 1'b1;
    tick();
    do_probe(32'hDEADA033, 1'b0, 3'd0, 9, "reset_probe");
  endtask

  task automatic test_write_read();
    do_write(3'd5, 32'h00402011, 32'h0, 32'h000048C2, 32'h00011581);
    do_read(3'd5, 32'h00402011, 32'h0, 32'h000048C2, 32'h00011580, "read_idx5");
    do_write(3'd1, 32'h7FFFFFAA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_read(3'd1, 32'h7FFFE0AA, 32'h1FFFE000, 32'h03FFFFC6, 32'h03FFFFC6, "read_idx1");
  endtask

  task automatic test_probe();
    probe_exp_t e;
    int cnt;
    do_probe(32'h00402011, 1'b1, 3'd5, 7, "probe_hit5");
    // ASID mismatch probe; a TLBW arriving mid-probe must be dropped
    e.m = 1'b0; e.idx = 3'd0; e.lat = 9;
    probe_q.push_back(e);
    bus.EntryHi_I   = 32'h00402012;
    bus.MMU_Func_I  = F_TLBP;
    bus.CP0_RdReq_I = 1'b1;
    tick();
    bus.CP0_RdReq_I = 1'b0;
    cnt = 0;
    while (bus.MMU_AckP_O !== 1'b1 && cnt < TMO) begin
      if (cnt == 2) begin
        bus.MMU_Func_I  = F_TLBW;
        bus.MMU_Index_I = 3'd4;
        bus.EntryLo0_I  = 32'h00000042;
        bus.EntryLo1_I  = 32'h00000042;
        bus.PageMask_I  = 32'h0;
        bus.CP0_WrReq_I = 1'b1;
      end else begin
        bus.CP0_WrReq_I = 1'b0;
        bus.MMU_Func_I  = F_TLBP;
      end
      tick();
      cnt++;
    end
    bus.CP0_WrReq_I = 1'b0;
    e = probe_q.pop_front();
    n_cmp++;
    if (cnt != e.lat || bus.MMU_Matched_O !== e.m || bus.MMU_Index_O !== e.idx) begin
      n_err++; $display("FAIL probe_asid_miss: got lat=%0d m=%b i=%0d want lat=%0d m=%b i=%0d",
                        cnt, bus.MMU_Matched_O, bus.MMU_Index_O, e.lat, e.m, e.idx);
    end
    tick();
    do_read(3'd4, 32'h0, 32'h0, 32'h0, 32'h0, "dropped_write");
  endtask

  task automatic test_priority();
    do_write(3'd6, 32'h00804011, 32'h0, 32'h00002EC2, 32'h0);
    do_write(3'd2, 32'h00804011, 32'h0, 32'h00002A82, 32'h0);
    do_probe(32'h00804011, 1'b1, 3'd2, 4, "probe_lowest");
    bus.ASID_I        = 8'h11;
    bus.Trans_VAddr_I = 32'h00804123;
    #1;
    n_cmp++;
    if ({bus.Trans_Miss_O, bus.Trans_PAddr_O} !== {1'b0, 32'h000AA123}) begin
      n_err++; $display("FAIL trans_lowest: got miss=%b pa=%h want 0/000aa123",
                        bus.Trans_Miss_O, bus.Trans_PAddr_O);
    end
  endtask

  task automatic test_translate();
    logic [31:0] va [4];
    logic [31:0] pa [4];
    logic        ms [4];
    logic [7:0]  as [4];
    va[0] = 32'h00402ABC; pa[0] = 32'h00123ABC; ms[0] = 1'b0; as[0] = 8'h11;
    va[1] = 32'h80001000; pa[1] = 32'h00001000; ms[1] = 1'b0; as[1] = 8'h11;
    va[2] = 32'hA0001000; pa[2] = 32'h00001000; ms[2] = 1'b0; as[2] = 8'h11;
    va[3] = 32'h00402ABC; pa[3] = 32'h00000000; ms[3] = 1'b1; as[3] = 8'h12;
    for (int i = 0; i < 4; i++) begin
      bus.ASID_I        = as[i];
      bus.Trans_VAddr_I = va[i];
      #1;
      n_cmp++;
      if ({bus.Trans_Miss_O, bus.Trans_PAddr_O} !== {ms[i], pa[i]}) begin
        n_err++; $display("FAIL trans_%0d: va=%h got miss=%b pa=%h want miss=%b pa=%h", i,
                          va[i], bus.Trans_Miss_O, bus.Trans_PAddr_O, ms[i], pa[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bv;
    bus.ASID_I        = 8'h11;
    bus.Trans_VAddr_I = 32'h00403ABC;
    bus.Trans_Req_I   = 1'b1;
    #1;
    n_cmp++;
    if ({bus.Trans_Miss_O, bus.Trans_PAddr_O} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL odd_invalid: got miss=%b pa=%h want 1/0",
                        bus.Trans_Miss_O, bus.Trans_PAddr_O);
    end
    fault_q.push_back(32'h00403ABC);
    tick();
    bus.Trans_VAddr_I = 32'h00600000;
    fault_q.push_back(32'h00600000);
    bv = fault_q.pop_front();
    n_cmp++;
    if ({bus.MMU_Req_O, bus.MMU_BadVAddr_O} !== {1'b1, bv}) begin
      n_err++; $display("FAIL fault1: got req=%b bv=%h want 1/%h", bus.MMU_Req_O,
                        bus.MMU_BadVAddr_O, bv);
    end
    tick();
    bus.Trans_VAddr_I = 32'h00402ABC;
    bv = fault_q.pop_front();
    n_cmp++;
    if ({bus.MMU_Req_O, bus.MMU_BadVAddr_O} !== {1'b1, bv}) begin
      n_err++; $display("FAIL fault2: got req=%b bv=%h want 1/%h", bus.MMU_Req_O,
                        bus.MMU_BadVAddr_O, bv);
    end
    tick();
    bus.Trans_Req_I = 1'b0;
    n_cmp++;
    if ({bus.MMU_Req_O, bus.MMU_BadVAddr_O} !== {1'b0, bv}) begin
      n_err++; $display("FAIL fault_hold: got req=%b bv=%h want 0/%h", bus.MMU_Req_O,
                        bus.MMU_BadVAddr_O, bv);
    end
    // TLBW and translation on the same edge: translation sees the old contents
    bus.MMU_Func_I    = F_TLBW;
    bus.MMU_Index_I   = 3'd3;
    bus.EntryHi_I     = 32'h01000011;
    bus.PageMask_I    = 32'h0;
    bus.EntryLo0_I    = 32'h0000C842;
    bus.EntryLo1_I    = 32'h0;
    bus.Trans_VAddr_I = 32'h01000000;
    bus.Trans_Req_I   = 1'b1;
    bus.CP0_WrReq_I   = 1'b1;
    fault_q.push_back(32'h01000000);
    tick();
    bus.CP0_WrReq_I = 1'b0;
    bus.Trans_Req_I = 1'b0;
    bv = fault_q.pop_front();
    n_cmp++;
    if ({bus.MMU_Req_O, bus.MMU_BadVAddr_O} !== {1'b1, bv}) begin
      n_err++; $display("FAIL write_vs_trans: got req=%b bv=%h want 1/%h", bus.MMU_Req_O,
                        bus.MMU_BadVAddr_O, bv);
    end
    n_cmp++;
    if ({bus.Trans_Miss_O, bus.Trans_PAddr_O} !== {1'b0, 32'h00321000}) begin
      n_err++; $display("FAIL post_write_trans: got miss=%b pa=%h want 0/00321000",
                        bus.Trans_Miss_O, bus.Trans_PAddr_O);
    end
    tick();
  endtask

  task automatic test_abort_and_hold();
    int acks;
    read_exp_t e;
    bus.EntryHi_I   = 32'hDEADA033;
    bus.MMU_Func_I  = F_TLBP;
    bus.CP0_RdReq_I = 1'b1;
    tick();
    bus.CP0_RdReq_I = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.Busy_O !== 1'b1) begin
      n_err++; $display("FAIL busy_mid_probe: got %b want 1", bus.Busy_O);
    end
    Reset_N = 1'b0;
    #1;
    n_cmp++;
    if ({bus.Busy_O, bus.MMU_AckP_O} !== 2'b00) begin
      n_err++; $display("FAIL abort_reset: got busy=%b ackp=%b want 0/0", bus.Busy_O,
                        bus.MMU_AckP_O);
    end
    tick();
    Reset_N = 1'b1;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.MMU_AckP_O === 1'b1 || bus.Busy_O === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_err++; $display("FAIL abort_no_ack: got %0d active cycles want 0", acks);
    end
    do_read(3'd5, 32'h0, 32'h0, 32'h0, 32'h0, "reset_cleared");
    do_write(3'd0, 32'h00402011, 32'h0, 32'h000048C2, 32'h00011581);
    e.hi = 32'h00402011; e.pm = 32'h0; e.lo0 = 32'h000048C2; e.lo1 = 32'h00011580;
    read_q.push_back(e);
    bus.MMU_Func_I  = F_TLBR;
    bus.MMU_Index_I = 3'd0;
    bus.CP0_RdReq_I = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) bus.CP0_RdReq_I = 1'b0;
      if (bus.MMU_AckR_O === 1'b1) begin
        acks++;
        if (read_q.size() > 0) begin
          e = read_q.pop_front();
          n_cmp++;
          if ({bus.MMU_EntryHi_O, bus.MMU_EntryLo0_O, bus.MMU_EntryLo1_O} !== {e.hi, e.lo0, e.lo1}) begin
            n_err++; $display("FAIL held_read_data: got %h/%h/%h want %h/%h/%h",
                              bus.MMU_EntryHi_O, bus.MMU_EntryLo0_O, bus.MMU_EntryLo1_O,
                              e.hi, e.lo0, e.lo1);
          end
        end
      end
    end
    n_cmp++;
    if (acks != 1) begin
      n_err++; $display("FAIL held_read_acks: got %0d want 1", acks);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset_N           = 1'b1;
    bus.MMU_Func_I    = 2'b00;
    bus.CP0_RdReq_I   = 1'b0;
    bus.CP0_WrReq_I   = 1'b0;
    bus.MMU_Index_I   = 3'd0;
    bus.EntryHi_I     = 32'h0;
    bus.PageMask_I    = 32'h0;
    bus.EntryLo0_I    = 32'h0;
    bus.EntryLo1_I    = 32'h0;
    bus.ASID_I        = 8'h0;
    bus.Trans_Req_I   = 1'b0;
    bus.Trans_VAddr_I = 32'h0;
    test_reset();
    test_write_read();
    test_probe();
    test_priority();
    test_translate();
    test_back_to_back();
    test_abort_and_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
